// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver with mid-bit sampling and a one-entry
//             valid/ready holding register; framing/overrun pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 1152000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;

    localparam logic [15:0] c_BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(HALF_PERIOD - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_FINISH    = 3'd4;
    localparam logic [2:0] c_WAIT_HIGH = 3'd5;

    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_q;
    logic [1:0]  r_warm;
    logic        r_armed;

    logic [2:0]  r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_stop_ok;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_start_edge;
    logic        w_accept;

    // r_armed only rises once a genuine high has passed the synchronizer, so a
    // line held low through reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_q  <= 1'b1;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
            r_rx_q  <= r_rx_s;
            r_warm  <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_start_edge = r_armed && r_rx_q && !r_rx_s;
    assign w_accept     = r_valid && ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_clk_cnt   <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_stop_ok   <= 1'b0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= c_START;
                        r_clk_cnt <= 16'd0;
                        r_busy    <= 1'b1;
                    end
                end

                c_START: begin
                    if (r_clk_cnt == c_HALF_LAST) begin
                        if (r_rx_s) begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= c_DATA;
                            r_clk_cnt <= 16'd0;
                            r_bit_cnt <= 3'd0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                c_DATA: begin
                    if (r_clk_cnt == c_BIT_LAST) begin
                        r_clk_cnt          <= 16'd0;
                        r_shift[r_bit_cnt] <= r_rx_s;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                c_STOP: begin
                    if (r_clk_cnt == c_BIT_LAST) begin
                        r_clk_cnt <= 16'd0;
                        r_stop_ok <= r_rx_s;
                        r_state   <= c_FINISH;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                // One cycle after the stop sample: commit the byte or flag it.
                // A same-cycle accept frees the holding register for the new byte.
                c_FINISH: begin
                    if (r_stop_ok) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        if (!r_valid || ready_i) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_WAIT_HIGH;
                    end
                end

                c_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= c_IDLE;
                    r_clk_cnt <= 16'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for uart_rx: stimulus queues expected bytes, rise times
// and flag counts; a negedge monitor pops and compares as the DUT delivers.
module tb_uart_rx;

    localparam int CLK_FREQ  = 100000000;
    localparam int BAUD_RATE = 1152000;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;
    // Start drive -> valid visible: 2 synchronizer flops + edge register,
    // half a bit to the start centre, nine bit periods, one commit cycle.
    localparam int RISE_LAT  = 3 + BIT / 2 + 9 * BIT + 1;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int exp_fe  = 0;
    int exp_ov  = 0;
    logic [7:0] exp_q[$];
    int         tq[$];
    logic       prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted byte, every valid rise and every flag pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, none expected (cycle %0d)", data_o, cyc);
                end else begin
                    check("rx_byte", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
                end
            end
            if (valid_o && !prev_v && tq.size() > 0) begin
                check("valid_rise_cycle", cyc, tq.pop_front());
            end
            if (frame_err_o) fe_seen++;
            if (overrun_o) ov_seen++;
            if (frame_err_o && overrun_o) begin
                checks++;
                errors++;
                $display("FAIL flags_together: frame_err=1 overrun=1, required not both (cycle %0d)", cyc);
            end
        end
        prev_v = valid_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame, LSB first; queues expectations before driving.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit push_byte, input bit push_time);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (push_byte) exp_q.push_back(b);
        if (push_time) tq.push_back(cyc + RISE_LAT);
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            tick(BIT);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string      msg;
        int         c0;
        int         gap;
        logic [7:0] rb;
        logic [7:0] b7e;

        rst = 1'b1;
        rx_i = 1'b1;
        ready_i = 1'b0;
        tick(3);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
        rst = 1'b0;
        tick(200);

        // Single byte with latency and busy checks
        ready_i = 1'b1;
        fork
            send_frame(8'h55, 1'b1, 1'b1, 1'b1);
            begin
                tick(400);
                check("busy_mid_frame", {31'd0, busy_o}, 32'd1);
            end
        join
        tick(20);
        check("busy_after_frame", {31'd0, busy_o}, 32'd0);

        // Back-to-back text
        msg = "Hello!\n";
        for (int i = 0; i < msg.len(); i++) begin
            send_frame(msg[i], 1'b1, 1'b1, 1'b1);
        end
        tick(100);
        check("hello_drained", exp_q.size(), 32'd0);
        check("hello_no_ferr", fe_seen, exp_fe);
        check("hello_no_ovr", ov_seen, exp_ov);

        // Short low glitch: false start
        c0 = cyc;
        rx_i = 1'b0;
        tick(10);
        check("glitch_busy_hi", {31'd0, busy_o}, 32'd1);
        tick(10);
        rx_i = 1'b1;
        tick(c0 + 47 - cyc);
        check("glitch_busy_lo", {31'd0, busy_o}, 32'd0);
        tick(900);
        check("glitch_stays_idle", {31'd0, busy_o}, 32'd0);

        // Framing error, long break, then recovery
        exp_fe++;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        tick(1000);
        check("break_busy", {31'd0, busy_o}, 32'd1);
        check("ferr_count", fe_seen, exp_fe);
        rx_i = 1'b1;
        tick(10);
        check("break_release_idle", {31'd0, busy_o}, 32'd0);
        tick(50);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        tick(50);
        check("after_break_drained", exp_q.size(), 32'd0);

        // Overrun with consumer stalled
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        exp_ov++;
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        tick(20);
        check("ovr_data_held", {24'd0, data_o}, 32'h11);
        check("ovr_valid_held", {31'd0, valid_o}, 32'd1);
        check("ovr_count", ov_seen, exp_ov);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        check("ovr_drained", {31'd0, valid_o}, 32'd0);

        // Accept on the completion cycle: replacement, no overrun
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        fork
            send_frame(8'h22, 1'b1, 1'b1, 1'b0);
            begin
                tick(RISE_LAT - 1);
                ready_i = 1'b1;
                tick(1);
                ready_i = 1'b0;
            end
        join
        tick(20);
        check("swap_data", {24'd0, data_o}, 32'h22);
        check("swap_valid", {31'd0, valid_o}, 32'd1);
        check("swap_no_ovr", ov_seen, exp_ov);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;

        // Reset mid-frame with a byte held
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("held_before_rst", {31'd0, valid_o}, 32'd1);
        b7e = 8'h7E;
        rx_i = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_i = b7e[i];
            tick(BIT);
        end
        rx_i = b7e[4];
        tick(BIT / 2);
        rx_i = 1'b0;
        rst = 1'b1;
        tick(2);
        check("mid_rst_data", {24'd0, data_o}, 32'd0);
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        tick(60);
        check("low_after_rst_no_edge", {31'd0, busy_o}, 32'd0);
        check("low_after_rst_no_valid", {31'd0, valid_o}, 32'd0);
        rx_i = 1'b1;
        tick(30);
        ready_i = 1'b1;
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        tick(30);

        // Randomized bytes with random gaps (zero gap = back-to-back)
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 150));
            tick(gap);
            send_frame(rb, 1'b1, 1'b1, 1'b1);
        end
        tick(100);

        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_time_queue_empty", tq.size(), 32'd0);
        check("final_ferr_count", fe_seen, exp_fe);
        check("final_ovr_count", ov_seen, exp_ov);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
